// File: rtl/bram_tdp.sv
// bram_tdp: single-clock true dual-port block RAM with byte-lane writes,
// 1- or 2-cycle read latency, per-port read-valid strobes and a post-reset clear engine.
module bram_tdp #(
  parameter int    WIDTH        = 128,
  parameter int    DEPTH        = 1024,
  parameter int    AW           = $clog2(DEPTH),
  parameter int    BYTE_W       = 8,
  parameter int    RD_LAT       = 1,
  parameter int    RDW_MODE     = 0,
  parameter int    CLEAR_ON_RST = 1,
  parameter string FILE         = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [WIDTH/BYTE_W-1:0] wea,
  input  logic [AW-1:0]           addra,
  input  logic [WIDTH-1:0]        dina,
  output logic [WIDTH-1:0]        douta,
  output logic                    dvalida,
  input  logic                    enb,
  input  logic [WIDTH/BYTE_W-1:0] web,
  input  logic [AW-1:0]           addrb,
  input  logic [WIDTH-1:0]        dinb,
  output logic [WIDTH-1:0]        doutb,
  output logic                    dvalidb,
  output logic                    busy
);
  localparam int              NB      = WIDTH / BYTE_W;
  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST    = IW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_READY} state_t;

  state_t           state;
  logic [IW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             acc_a, acc_b;
  logic             rng_a, rng_b;
  logic             wr_a, wr_b;
  logic [IW-1:0]    ia, ib;
  logic [WIDTH-1:0] old_a, old_b;
  logic [WIDTH-1:0] rd_a, rd_b;

  logic             vld_a_p0, vld_b_p0;
  logic [WIDTH-1:0] dout_a_p0, dout_b_p0;

  // Word as it looks after the byte lanes selected by we are overwritten with din.
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old,
                                                   input logic [WIDTH-1:0] din,
                                                   input logic [NB-1:0]    we);
    logic [WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) r[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  // Clear engine: IDLE for one cycle after reset, then sweep every word once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (CLEAR_ON_RST != 0) begin
            state <= S_CLEAR;
          end else begin
            state <= S_READY;
            busy  <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state <= S_READY;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_READY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Access decode and read-data selection; out-of-range accesses read as zero.
  always_comb begin
    acc_a = ena & ~busy;
    acc_b = enb & ~busy;
    rng_a = ({1'b0, addra} < DEPTH_L);
    rng_b = ({1'b0, addrb} < DEPTH_L);
    ia    = IW'(addra);
    ib    = IW'(addrb);
    wr_a  = acc_a & rng_a;
    wr_b  = acc_b & rng_b;
    old_a = rng_a ? mem[ia] : '0;
    old_b = rng_b ? mem[ib] : '0;
    rd_a  = old_a;
    rd_b  = old_b;
    if (RDW_MODE != 0) begin
      if (rng_a) rd_a = merge_lanes(old_a, dina, wea);
      if (rng_b) rd_b = merge_lanes(old_b, dinb, web);
    end
  end

  // Port B lanes are written first so port A wins any lane both ports enable.
  always @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && web[i]) mem[ib][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
      end
      for (int i = 0; i < NB; i++) begin
        if (wr_a && wea[i]) mem[ia][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage p0: array read register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a_p0  <= 1'b0;
      vld_b_p0  <= 1'b0;
      dout_a_p0 <= '0;
      dout_b_p0 <= '0;
    end else begin
      vld_a_p0 <= acc_a;
      vld_b_p0 <= acc_b;
      if (acc_a) dout_a_p0 <= rd_a;
      if (acc_b) dout_b_p0 <= rd_b;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             vld_a_p1, vld_b_p1;
    logic [WIDTH-1:0] dout_a_p1, dout_b_p1;

    // Stage p1: optional output register
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_a_p1  <= 1'b0;
        vld_b_p1  <= 1'b0;
        dout_a_p1 <= '0;
        dout_b_p1 <= '0;
      end else begin
        vld_a_p1 <= vld_a_p0;
        vld_b_p1 <= vld_b_p0;
        if (vld_a_p0) dout_a_p1 <= dout_a_p0;
        if (vld_b_p0) dout_b_p1 <= dout_b_p0;
      end
    end

    assign douta   = dout_a_p1;
    assign doutb   = dout_b_p1;
    assign dvalida = vld_a_p1;
    assign dvalidb = vld_b_p1;
  end else begin : g_lat1
    assign douta   = dout_a_p0;
    assign doutb   = dout_b_p0;
    assign dvalida = vld_a_p0;
    assign dvalidb = vld_b_p0;
  end

endmodule

// File: tb/tb_bram_tdp.sv
// tb_bram_tdp: directed checks of bram_tdp in three configurations sharing one stimulus:
// u1 RD_LAT=1/read-first, u2 RD_LAT=2/write-first, u3 without clear engine.
module tb_bram_tdp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int NB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena, enb;
  logic [NB-1:0]    wea, web;
  logic [AW-1:0]    addra, addrb;
  logic [WIDTH-1:0] dina, dinb;

  logic [WIDTH-1:0] douta1, doutb1, douta2, doutb2, douta3, doutb3;
  logic             dvalida1, dvalidb1, dvalida2, dvalidb2, dvalida3, dvalidb3;
  logic             busy1, busy2, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_tdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(0),
             .CLEAR_ON_RST(1)) u1 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .dvalida(dvalida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .dvalidb(dvalidb1),
    .busy(busy1));

  bram_tdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYTE_W(8), .RD_LAT(2), .RDW_MODE(1),
             .CLEAR_ON_RST(1)) u2 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta2), .dvalida(dvalida2),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb2), .dvalidb(dvalidb2),
    .busy(busy2));

  bram_tdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(0),
             .CLEAR_ON_RST(0)) u3 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta3), .dvalida(dvalida3),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb3), .dvalidb(dvalidb3),
    .busy(busy3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Release reset and follow the clear; accesses are driven throughout and must be ignored.
  task automatic clear_phase(input string pfx);
    rst = 1'b0;
    ena = 1'b1; wea = 4'hF; addra = 5'd2;  dina = 32'hDEAD_BEEF;
    enb = 1'b1; web = 4'h0; addrb = 5'd12; dinb = 32'h0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("%s_busy1_k%0d", pfx, k), busy1, (k <= 16) ? 1 : 0);
      chk($sformatf("%s_busy2_k%0d", pfx, k), busy2, (k <= 16) ? 1 : 0);
      if (k == 1) chk($sformatf("%s_busy3_k1", pfx), busy3, 0);
      if (k <= 16) begin
        chk($sformatf("%s_dva1_k%0d", pfx, k), dvalida1, 0);
        chk($sformatf("%s_dvb1_k%0d", pfx, k), dvalidb1, 0);
        chk($sformatf("%s_dva2_k%0d", pfx, k), dvalida2, 0);
        chk($sformatf("%s_dvb2_k%0d", pfx, k), dvalidb2, 0);
      end
      if (k == 16) begin
        ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    tick();
    tick();
    chk("rst_busy1", busy1, 1);
    chk("rst_busy3", busy3, 1);
    chk("rst_douta1", douta1, 0);
    chk("rst_dva1", dvalida1, 0);
    chk("rst_douta2", douta2, 0);
    chk("rst_dvb2", dvalidb2, 0);

    clear_phase("clr");

    // Read back every word on port A
    for (int i = 0; i <= 16; i++) begin
      ena = (i < 16); wea = 4'h0; addra = AW'(i);
      tick();
      if (i < 16) begin
        chk($sformatf("clr_rd1_%0d", i), douta1, 0);
        chk($sformatf("clr_dv1_%0d", i), dvalida1, 1);
      end else begin
        chk("clr_dv1_end", dvalida1, 0);
      end
      if (i >= 1) begin
        chk($sformatf("clr_rd2_%0d", i - 1), douta2, 0);
        chk($sformatf("clr_dv2_%0d", i - 1), dvalida2, 1);
      end
    end
    ena = 1'b0;
    tick();
    chk("clr_dv2_end", dvalida2, 0);

    // Byte-lane write
    ena = 1'b1; wea = 4'hF; addra = 5'd3; dina = 32'hAABB_CCDD;
    tick();
    wea = 4'b0101; dina = 32'h1122_3344;
    tick();
    chk("bl_rdw_old1", douta1, 32'hAABB_CCDD);
    chk("bl_first2", douta2, 32'hAABB_CCDD);
    wea = 4'h0;
    tick();
    chk("bl_rd1", douta1, 32'hAA22_CC44);
    chk("bl_merge2", douta2, 32'hAA22_CC44);
    ena = 1'b0;
    tick();
    chk("bl_rd2", douta2, 32'hAA22_CC44);

    // Read-during-write on the same and the other port
    ena = 1'b1; wea = 4'hF; addra = 5'd7; dina = 32'h9;
    tick();
    dina = 32'h5; enb = 1'b1; web = 4'h0; addrb = 5'd7;
    tick();
    chk("rdw_a1_old", douta1, 32'h9);
    chk("rdw_b1_old", doutb1, 32'h9);
    ena = 1'b0; wea = 4'h0;
    tick();
    chk("rdw_a2_new", douta2, 32'h5);
    chk("rdw_b2_old", doutb2, 32'h9);
    chk("rdw_b1_next", doutb1, 32'h5);
    enb = 1'b0;
    tick();
    chk("rdw_b2_next", doutb2, 32'h5);

    // Same-address collision
    ena = 1'b1; wea = 4'b0011; addra = 5'd9; dina = 32'h1111_1111;
    enb = 1'b1; web = 4'b1111; addrb = 5'd9; dinb = 32'h2222_2222;
    tick();
    wea = 4'h0; enb = 1'b0; web = 4'h0;
    tick();
    chk("col_rd1", douta1, 32'h2222_1111);
    ena = 1'b0;
    tick();
    chk("col_rd2", douta2, 32'h2222_1111);

    // Fill, then stream 8 reads per port
    for (int i = 0; i < 8; i++) begin
      ena = 1'b1; wea = 4'hF; addra = AW'(i);     dina = 32'hA000_0000 + 32'(i);
      enb = 1'b1; web = 4'hF; addrb = AW'(8 + i); dinb = 32'hB000_0000 + 32'(i);
      tick();
    end
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    tick();
    tick();
    for (int i = 0; i <= 9; i++) begin
      ena = (i < 8); enb = (i < 8); addra = AW'(i); addrb = AW'(8 + i);
      tick();
      if (i < 8) begin
        chk($sformatf("pl_a1_%0d", i), douta1, 32'hA000_0000 + 32'(i));
        chk($sformatf("pl_b1_%0d", i), doutb1, 32'hB000_0000 + 32'(i));
        chk($sformatf("pl_dva1_%0d", i), dvalida1, 1);
        chk($sformatf("pl_dvb1_%0d", i), dvalidb1, 1);
      end else begin
        chk($sformatf("pl_dva1_%0d", i), dvalida1, 0);
        chk($sformatf("pl_dvb1_%0d", i), dvalidb1, 0);
      end
      if (i >= 1 && i <= 8) begin
        chk($sformatf("pl_a2_%0d", i), douta2, 32'hA000_0000 + 32'(i - 1));
        chk($sformatf("pl_b2_%0d", i), doutb2, 32'hB000_0000 + 32'(i - 1));
        chk($sformatf("pl_dva2_%0d", i), dvalida2, 1);
        chk($sformatf("pl_dvb2_%0d", i), dvalidb2, 1);
      end else begin
        chk($sformatf("pl_dva2_%0d", i), dvalida2, 0);
        chk($sformatf("pl_dvb2_%0d", i), dvalidb2, 0);
      end
    end

    // Out-of-range address 20 aliases word 4 in the low bits; it must not write
    ena = 1'b1; wea = 4'hF; addra = 5'd20; dina = 32'hFFFF_FFFF;
    tick();
    chk("oor_rd1", douta1, 0);
    chk("oor_dv1", dvalida1, 1);
    wea = 4'h0; addra = 5'd4;
    tick();
    chk("oor_rd2", douta2, 0);
    chk("oor_dv2", dvalida2, 1);
    chk("oor_w4_1", douta1, 32'hA000_0004);
    ena = 1'b0;
    tick();
    chk("oor_w4_2", douta2, 32'hA000_0004);
    chk("hold_rd1", douta1, 32'hA000_0004);
    chk("hold_dv1", dvalida1, 0);

    // Read accepted just before reset must not emerge after the reset edge
    ena = 1'b1; addra = 5'd1;
    tick();
    chk("fl_dv1", dvalida1, 1);
    ena = 1'b0; rst = 1'b1;
    tick();
    chk("fl_dv2", dvalida2, 0);
    chk("fl_dv1_rst", dvalida1, 0);
    chk("fl_rd1_rst", douta1, 0);
    chk("fl_rd2_rst", douta2, 0);
    chk("fl_busy1", busy1, 1);

    // Abort the clear after word 8, reset again, then watch a full clear
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_busy1", busy1, 1);
    rst = 1'b1;
    tick();
    clear_phase("mid");

    for (int i = 0; i <= 16; i++) begin
      enb = (i < 16); web = 4'h0; addrb = AW'(i);
      tick();
      if (i < 16) begin
        chk($sformatf("mid_rd1_%0d", i), doutb1, 0);
        chk($sformatf("mid_dv1_%0d", i), dvalidb1, 1);
      end
      if (i >= 1) chk($sformatf("mid_rd2_%0d", i - 1), doutb2, 0);
    end
    enb = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
